// File: rtl/fetch_ctrl.sv
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Program-counter owner and instruction-fetch sequencer with
//                decode handshake and branch/jump/jr redirect handling.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        br_valid,
    input  logic [1:0]  br_sel,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [25:0] br_imm,
    input  logic [31:0] br_reg,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic [31:0] br_pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] target;

    always_comb begin
        br_pc_plus4 = br_pc + 32'd4;
        br_offset   = {{14{br_imm[15]}}, br_imm[15:0], 2'b00};
        redirect    = br_valid && (br_sel != 2'b00);
        case (br_sel)
            2'b01:   target = br_taken ? (br_pc_plus4 + br_offset) : br_pc_plus4;
            2'b10:   target = {br_pc_plus4[31:28], br_imm, 2'b00};
            2'b11:   target = {br_reg[31:2], 2'b00};
            default: target = br_pc_plus4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        valid_d    = valid_q;
        misalign_d = redirect && (br_sel == 2'b11) && (br_reg[1:0] != 2'b00);

        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    // An issued request cannot be withdrawn; drain it unless it completes now.
                    pc_d    = target;
                    valid_d = 1'b0;
                    state_d = (req_q && !imem_ack) ? S_DRAIN : S_REQ;
                end else if (req_q && imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    valid_d   = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                end
                if (imem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // The address only follows the PC when a fresh request is about to be issued.
        addr_d = (state_d == S_REQ) ? pc_d : addr_q;
        req_d  = (state_d != S_HOLD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            inst_q     <= 32'd0;
            inst_pc_q  <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign misalign   = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Directed, table-driven self-checking bench for fetch_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    logic        clk;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        br_valid;
    logic [1:0]  br_sel;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [25:0] br_imm;
    logic [31:0] br_reg;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .br_valid   (br_valid),
        .br_sel     (br_sel),
        .br_taken   (br_taken),
        .br_pc      (br_pc),
        .br_imm     (br_imm),
        .br_reg     (br_reg),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        bv;
        logic [1:0]  sel;
        logic        taken;
        logic [31:0] bpc;
        logic [25:0] bimm;
        logic [31:0] breg;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ack, input logic [31:0] rdata, input logic ready,
                       input logic bv, input logic [1:0] sel, input logic taken,
                       input logic [31:0] bpc, input logic [25:0] bimm, input logic [31:0] breg,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_inst, input logic [31:0] e_ipc, input logic e_mis);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.ready = ready;
        v.bv = bv; v.sel = sel; v.taken = taken; v.bpc = bpc; v.bimm = bimm; v.breg = breg;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_mis = e_mis;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, step, act, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
        br_valid = 1'b0; br_sel = 2'b00; br_taken = 1'b0;
        br_pc = 32'd0; br_imm = 26'd0; br_reg = 32'd0;
    endtask

    initial begin
        // columns: ack rdata ready | bv sel taken br_pc br_imm br_reg | req addr valid inst inst_pc misalign
        // sequential fetch
        add(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h3000,     0, 32'h0,         32'h0,        0);
        add(1, 32'h1111_0000, 1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'h1111_0000, 32'h3000,     0);
        add(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h3004,     0, 32'h0,         32'h0,        0);
        add(1, 32'h2222_0004, 1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'h2222_0004, 32'h3004,     0);
        add(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h3008,     0, 32'h0,         32'h0,        0);
        add(1, 32'h3333_0008, 0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'h3333_0008, 32'h3008,     0);
        // backpressure: five cycles of ready=0
        for (int i = 0; i < 5; i++)
            add(0, 32'h0,     0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'h3333_0008, 32'h3008,     0);
        add(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h300C,     0, 32'h0,         32'h0,        0);
        add(1, 32'h4444_000C, 0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'h4444_000C, 32'h300C,     0);
        // beq taken in HOLD with ready=1: held instruction dropped
        add(0, 32'h0,         1, 1, 2'b01, 1, 32'h3004,      26'h000FFFE, 32'h0,     1, 32'h3000,     0, 32'h0,         32'h0,        0);
        add(1, 32'h5555_3000, 0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'h5555_3000, 32'h3000,     0);
        add(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h3004,     0, 32'h0,         32'h0,        0);
        // beq not taken while request outstanding -> drain old address
        add(0, 32'h0,         0, 1, 2'b01, 0, 32'h3004,      26'h000FFFE, 32'h0,     1, 32'h3004,     0, 32'h0,         32'h0,        0);
        add(1, 32'hDEAD_BEEF, 0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h3008,     0, 32'h0,         32'h0,        0);
        add(1, 32'h6666_3008, 0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'h6666_3008, 32'h3008,     0);
        // j
        add(0, 32'h0,         0, 1, 2'b10, 0, 32'h3000,      26'h0000C10, 32'h0,     1, 32'h3040,     0, 32'h0,         32'h0,        0);
        add(1, 32'h7777_3040, 0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'h7777_3040, 32'h3040,     0);
        // jr misaligned, misalign pulses for one cycle
        add(0, 32'h0,         0, 1, 2'b11, 0, 32'h0,         26'h0,       32'h3012,  1, 32'h3010,     0, 32'h0,         32'h0,        1);
        add(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h3010,     0, 32'h0,         32'h0,        0);
        add(1, 32'h8888_3010, 0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'h8888_3010, 32'h3010,     0);
        // br_valid with br_sel=00 has no effect
        add(0, 32'h0,         0, 1, 2'b00, 1, 32'h5000,      26'h0000C10, 32'h4000,  0, 32'h0,        1, 32'h8888_3010, 32'h3010,     0);
        add(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h3014,     0, 32'h0,         32'h0,        0);
        // ack delayed 3 cycles; second redirect in DRAIN wins
        add(0, 32'h0,         0, 1, 2'b10, 0, 32'h3000,      26'h0000100, 32'h0,     1, 32'h3014,     0, 32'h0,         32'h0,        0);
        add(0, 32'h0,         0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h3014,     0, 32'h0,         32'h0,        0);
        add(0, 32'h0,         0, 1, 2'b11, 0, 32'h0,         26'h0,       32'h0500,  1, 32'h3014,     0, 32'h0,         32'h0,        0);
        add(1, 32'hBAD0_0001, 0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h0500,     0, 32'h0,         32'h0,        0);
        add(1, 32'h9999_0500, 0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'h9999_0500, 32'h0500,     0);
        add(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h0504,     0, 32'h0,         32'h0,        0);
        // redirect on the same edge as the ack
        add(1, 32'hBAD0_0002, 0, 1, 2'b01, 1, 32'h0600,      26'h0000004, 32'h0,     1, 32'h0614,     0, 32'h0,         32'h0,        0);
        add(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h0614,     0, 32'h0,         32'h0,        0);
        add(1, 32'hAAAA_0614, 0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'hAAAA_0614, 32'h0614,     0);
        // PC wrap: j to 0xFFFFFFFC then advance to 0
        add(0, 32'h0,         0, 1, 2'b10, 0, 32'hF000_0000, 26'h3FFFFFF, 32'h0,     1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,        0);
        add(1, 32'hBBBB_FFFC, 0, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     0, 32'h0,        1, 32'hBBBB_FFFC, 32'hFFFF_FFFC, 0);
        add(0, 32'h0,         1, 0, 2'b00, 0, 32'h0,         26'h0,       32'h0,     1, 32'h0000_0000, 0, 32'h0,        32'h0,        0);
        // enter DRAIN for the reset-mid-fetch sequence
        add(0, 32'h0,         0, 1, 2'b11, 0, 32'h0,         26'h0,       32'h0700,  1, 32'h0000_0000, 0, 32'h0,        32'h0,        0);

        // reset state
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req",      -1, {31'd0, imem_req},   32'd0);
        chk("reset_valid",    -1, {31'd0, inst_valid}, 32'd0);
        chk("reset_inst",     -1, inst,                32'd0);
        chk("reset_inst_pc",  -1, inst_pc,             32'd0);
        chk("reset_misalign", -1, {31'd0, misalign},   32'd0);
        rstn = 1'b1;
        #1;
        chk("req_low_before_first_edge", -1, {31'd0, imem_req}, 32'd0);

        foreach (vecs[i]) begin
            imem_ack   = vecs[i].ack;
            imem_rdata = vecs[i].rdata;
            inst_ready = vecs[i].ready;
            br_valid   = vecs[i].bv;
            br_sel     = vecs[i].sel;
            br_taken   = vecs[i].taken;
            br_pc      = vecs[i].bpc;
            br_imm     = vecs[i].bimm;
            br_reg     = vecs[i].breg;
            @(posedge clk);
            #1;
            chk("imem_req",   i, {31'd0, imem_req},   {31'd0, vecs[i].e_req});
            chk("inst_valid", i, {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
            chk("misalign",   i, {31'd0, misalign},   {31'd0, vecs[i].e_mis});
            if (vecs[i].e_req)
                chk("imem_addr", i, imem_addr, vecs[i].e_addr);
            if (vecs[i].e_valid) begin
                chk("inst",    i, inst,    vecs[i].e_inst);
                chk("inst_pc", i, inst_pc, vecs[i].e_ipc);
            end
        end

        // asynchronous reset while draining
        idle_inputs();
        rstn = 1'b0;
        #1;
        chk("drain_reset_req",   -2, {31'd0, imem_req},   32'd0);
        chk("drain_reset_valid", -2, {31'd0, inst_valid}, 32'd0);
        chk("drain_reset_inst",  -2, inst,                32'd0);
        chk("drain_reset_ipc",   -2, inst_pc,             32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("post_release_req_low", -2, {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_release_req",  -2, {31'd0, imem_req}, 32'd1);
        chk("post_release_addr", -2, imem_addr,         32'h0000_3000);
        imem_ack   = 1'b1;
        imem_rdata = 32'hCCCC_3000;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        chk("post_release_valid", -2, {31'd0, inst_valid}, 32'd1);
        chk("post_release_ipc",   -2, inst_pc,             32'h0000_3000);
        chk("post_release_inst",  -2, inst,                32'hCCCC_3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
